// File: rtl/input_conditioner_pkg.sv
// Shared constants, debounce state type and counter sizing
// for the button/switch input conditioner.
package input_conditioner_pkg;

  localparam int N_BTN           = 4;
  localparam int N_SW            = 10;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 500000;

  typedef enum logic {
    DB_IDLE,
    DB_PENDING
  } db_state_e;

  // Counter must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input bit: synchroniser, optional inversion, debounce FSM.
// Ports: clk_clk, reset_reset_n, raw_in, reset_val -> level, rise, fall.
module debounce_cell
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 8,
  parameter bit INVERT          = 1'b0
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic raw_in,
  input  logic reset_val,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  db_state_e              state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, fall_q;
  logic                   diff, term;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_q <= {SYNC_STAGES{reset_val}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  // Buttons flip here so the FSM always sees active-high.
  assign synced = sync_q[SYNC_STAGES-1] ^ INVERT;
  assign diff   = synced ^ stable_q;
  assign term   = (cnt_q == TERM);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= DB_IDLE;
      cnt_q    <= '0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= stable_d & ~stable_q;
      fall_q   <= ~stable_d & stable_q;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DB_IDLE:    if (diff) state_d = DB_PENDING;
      DB_PENDING: if (!diff || term) state_d = DB_IDLE;
      default:    state_d = DB_IDLE;
    endcase
  end

  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    unique case (1'b1)
      (state_q == DB_IDLE) && diff:
        cnt_d = CW'(1);
      (state_q == DB_PENDING) && diff && !term:
        cnt_d = cnt_q + 1'b1;
      (state_q == DB_PENDING) && diff && term:
        stable_d = synced;
      default: ;
    endcase
  end

  assign level = stable_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/input_conditioner.sv
// Debounced button/switch front-end for the Nios PIO inputs.
// Ports: raw buttons/switches in; levels, pulses, event_any out.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int N_BTN           = input_conditioner_pkg::N_BTN,
  parameter int N_SW            = input_conditioner_pkg::N_SW,
  parameter int SYNC_STAGES     = input_conditioner_pkg::SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = input_conditioner_pkg::DEBOUNCE_CYCLES
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [N_BTN-1:0] btn_n_raw,
  input  logic [N_SW-1:0]  sw_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_release,
  output logic [N_SW-1:0]  sw_level,
  output logic [N_SW-1:0]  sw_change,
  output logic             event_any
);

  logic [N_SW-1:0] sw_rise, sw_fall;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    debounce_cell #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (1'b1)
    ) u_cell (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .raw_in        (btn_n_raw[i]),
      .reset_val     (1'b1),
      .level         (btn_level[i]),
      .rise          (btn_press[i]),
      .fall          (btn_release[i])
    );
  end

  for (genvar i = 0; i < N_SW; i++) begin : g_sw
    debounce_cell #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .INVERT          (1'b0)
    ) u_cell (
      .clk_clk       (clk_clk),
      .reset_reset_n (reset_reset_n),
      .raw_in        (sw_raw[i]),
      .reset_val     (1'b0),
      .level         (sw_level[i]),
      .rise          (sw_rise[i]),
      .fall          (sw_fall[i])
    );
  end

  assign sw_change = sw_rise | sw_fall;
  assign event_any = |{btn_press, btn_release, sw_change};

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Upstream front-end for the Nios button and switch PIO inputs.
- Synchronises the raw DE-board pushbuttons (active-low) and slide switches into the clk_clk domain.
- Debounces every bit independently and presents clean active-high levels to button_external_connection_export / switch_external_connection_export.
- Emits single-cycle press/release/change pulses and a combined event flag for fabric logic and PIO edge capture.

Parameters:
- N_BTN, 4, number of pushbutton inputs
- N_SW, 10, number of slide-switch inputs
- SYNC_STAGES, 2, synchroniser depth; legal range 2..4
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required (10 ms at 50 MHz); minimum 2

Ports:
- clk_clk  in  1  system clock (50 MHz)
- reset_reset_n  in  1  asynchronous active-low reset
- btn_n_raw  in  N_BTN  raw pushbuttons, 0 = pressed
- sw_raw  in  N_SW  raw slide switches, 1 = up
- btn_level  out  N_BTN  debounced, 1 = pressed; drives button PIO
- btn_press  out  N_BTN  1-cycle pulse on debounced press
- btn_release  out  N_BTN  1-cycle pulse on debounced release
- sw_level  out  N_SW  debounced switch level; drives switch PIO
- sw_change  out  N_SW  1-cycle pulse on any debounced switch transition
- event_any  out  1  OR of all btn_press, btn_release and sw_change, same cycle

Behaviour:
- Reset and clocking: one clock domain, clk_clk. Reset is asynchronous assert, active-low on reset_reset_n; deassertion is sampled on clk_clk.
- Reset values:
  - Button synchroniser flops = 1 (released).
  - Switch synchroniser flops = 0.
  - btn_level = 0, sw_level = 0.
  - All pulses = 0, event_any = 0.
  - All debounce counters = 0.
- Synchroniser: SYNC_STAGES flops per bit, no logic between stages. Buttons are inverted after the last stage, so the debouncer works active-high for every input.
- Per-bit debounce cell: 2-state FSM holding `stable` plus a counter of width $clog2(DEBOUNCE_CYCLES).
  - IDLE: synced == stable; counter held at 0. synced != stable -> PENDING, counter = 1.
  - PENDING, synced != stable, counter < DEBOUNCE_CYCLES-1: counter increments.
  - PENDING, synced != stable, counter == DEBOUNCE_CYCLES-1: stable <= synced, counter <= 0, pulse asserted for exactly the next cycle, -> IDLE.
  - PENDING, synced == stable (bounce): counter <= 0, -> IDLE, no pulse.
- Latency: a clean raw transition first sampled at edge 1 is visible on the level output and its pulse after edge SYNC_STAGES + DEBOUNCE_CYCLES. The pulse is registered and coincident with the level change.
- Glitch rejection: a raw glitch shorter than DEBOUNCE_CYCLES synced cycles never changes the level and never pulses.
- Pulse decode:
  - btn_press = rising edge of stable, btn_release = falling edge.
  - sw_change fires on either edge.
  - Press and release for one bit can never be high in the same cycle.
- Independence: bits are fully independent. Simultaneous transitions on several bits give simultaneous pulses; event_any is a single cycle.
- Counter: never wraps; saturation is impossible by construction because the cell always reaches the terminal count or resets.
- Reset mid-debounce: counter and FSM clear immediately with no pulse. After release, inputs held at a non-reset value re-qualify after the full latency and then pulse. This means a switch up at power-on yields one sw_change after reset, which is required behaviour.

Decomposition:
- Package input_conditioner_pkg:
  - Default constants: N_BTN, N_SW, SYNC_STAGES, DEBOUNCE_CYCLES.
  - Debounce state enum {DB_IDLE, DB_PENDING}.
  - Function returning counter width.
- Sub-module debounce_cell: single bit, holding the synchroniser, FSM and counter, with ports clk_clk, reset_reset_n, raw_in, reset_val, level, rise, fall.
- Top: instantiates N_BTN + N_SW cells via generate, plus inversion and the event_any OR.

Test Plan (SYNC_STAGES=2, DEBOUNCE_CYCLES=8):
- Reset with btn_n_raw=4'hF, sw_raw=0, 20 cycles -> all outputs 0, no pulses.
- btn_n_raw[0] 1->0 held -> btn_level[0]=1 and btn_press[0]=1 for exactly one cycle, 10 edges after first sample; event_any high in that cycle; release gives btn_release[0] at the same latency.
- btn_n_raw[1] low for 5 cycles then high, repeated 4 times (bounce) -> btn_level[1] stays 0, no pulses; then hold low 8+ cycles -> single press pulse.
- sw_raw=10'h3FF and btn_n_raw=4'h0 in the same cycle -> sw_level=3FF, btn_level=F, all 14 pulses in one identical cycle, event_any single cycle.
- sw_raw[5]=1, assert reset_reset_n=0 at counter 5, release after 3 cycles -> no pulse during or at reset; sw_change[5] fires 10 edges after release.
- Reset released with sw_raw=10'h201 -> sw_change pulses on bits 0 and 9 once; no further pulses while static for 100 cycles.
